geri_yaz_asamasi: RTL and testbench

- Writeback stage; sits directly downstream of the memory-stage wrapper and consumes its registered outputs.
- Selects the write-back source: ALU/execute result, data-cache load data, or I/O read data.
- Waits for late cache or I/O data, stalling the pipeline while it waits.
- Drives the register-file write port and a forwarding bus. Detects lost load responses with a timeout.

---
 rtl/geri_yaz_asamasi_pkg.sv | 29 ++
 rtl/geri_yaz_asamasi_zaman_asimi_sayaci.sv | 44 ++++
 rtl/geri_yaz_asamasi.sv | 194 +++++++++++++++++++
 tb/tb_geri_yaz_asamasi.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/geri_yaz_asamasi_pkg.sv
// ============================================================================
// geri_yaz_paket: shared state encodings and helpers for the writeback stage.
// Revision: 1.0
// ============================================================================
`default_nettype none

package geri_yaz_paket;

    localparam int YAZMAC_ADRES_BIT = 5;

    localparam logic [1:0] GY_BOSTA        = 2'd0;
    localparam logic [1:0] GY_BELLEK_BEKLE = 2'd1;
    localparam logic [1:0] GY_GC_BEKLE     = 2'd2;

    typedef enum logic [1:0] {
        BOSTA        = GY_BOSTA,
        BELLEK_BEKLE = GY_BELLEK_BEKLE,
        GC_BEKLE     = GY_GC_BEKLE
    } gy_durum_t;

    // Register x0 is hard-wired, so a write to it is dropped.
    function automatic logic yazma_izni(input logic                        yaz,
                                        input logic [YAZMAC_ADRES_BIT-1:0] adres);
        return yaz && (adres != '0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/geri_yaz_asamasi_zaman_asimi_sayaci.sv
// ============================================================================
// zaman_asimi_sayaci: wait-cycle counter with clear, enable and terminal flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module zaman_asimi_sayaci #(
    parameter int ZAMAN_ASIMI = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic temizle_i,
    input  logic sayac_en_i,
    output logic son_o
);

    localparam int                   SAYAC_BIT = $clog2(ZAMAN_ASIMI);
    localparam logic [SAYAC_BIT-1:0] SON_DEGER = SAYAC_BIT'(ZAMAN_ASIMI - 1);

    logic [SAYAC_BIT-1:0] sayac_q;
    logic [SAYAC_BIT-1:0] sayac_d;

    always_comb begin
        sayac_d = sayac_q;
        if (temizle_i) begin
            sayac_d = '0;
        end else if (sayac_en_i) begin
            sayac_d = sayac_q + SAYAC_BIT'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sayac_q <= '0;
        end else begin
            sayac_q <= sayac_d;
        end
    end

    assign son_o = (sayac_q == SON_DEGER);

endmodule

`default_nettype wire

// File: rtl/geri_yaz_asamasi.sv
// ============================================================================
// geri_yaz_asamasi: writeback stage with load wait, stall and load timeout.
// Optional retired-instruction counter enabled by GERI_YAZ_SAYAC_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module geri_yaz_asamasi
    import geri_yaz_paket::*;
#(
    parameter int VERI_BIT    = 32,
    parameter int ZAMAN_ASIMI = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [VERI_BIT-1:0]         hedef_yazmac_verisi_i,
    input  logic                        yazmaca_yaz_i,
    input  logic [YAZMAC_ADRES_BIT-1:0] hedef_yazmaci_i,
    input  logic                        bellekten_oku_i,
    input  logic                        gc_aktif_i,
    input  logic                        bellek_veri_hazir_i,
    input  logic [VERI_BIT-1:0]         bellek_veri_i,
    input  logic                        gc_veri_gecerli_i,
    input  logic [VERI_BIT-1:0]         gc_okunan_veri_i,
    output logic                        yaz_o,
    output logic [YAZMAC_ADRES_BIT-1:0] yazmac_adres_o,
    output logic [VERI_BIT-1:0]         yazmac_veri_o,
    output logic                        ileri_gecerli_o,
    output logic [YAZMAC_ADRES_BIT-1:0] ileri_adres_o,
    output logic [VERI_BIT-1:0]         ileri_veri_o,
    output logic                        durdur_o,
    output logic                        hata_o
`ifdef GERI_YAZ_SAYAC_EN
    ,
    output logic [63:0]                 emekli_sayac_o
`endif
);

    gy_durum_t                   durum_q, durum_d;
    logic [YAZMAC_ADRES_BIT-1:0] bekleyen_adres_q, bekleyen_adres_d;
    logic                        bekleyen_yaz_q, bekleyen_yaz_d;
    logic                        yaz_q, yaz_d;
    logic [YAZMAC_ADRES_BIT-1:0] yazmac_adres_q, yazmac_adres_d;
    logic [VERI_BIT-1:0]         yazmac_veri_q, yazmac_veri_d;
    logic                        hata_q, hata_d;

    logic                        tamamlandi;
    logic                        sayac_temizle;
    logic                        sayac_en;
    logic                        sayac_son;
    logic                        kabul_gecerli;
    logic [VERI_BIT-1:0]         kabul_veri;
    logic                        bekle_gecerli;
    logic [VERI_BIT-1:0]         bekle_veri;

    zaman_asimi_sayaci #(
        .ZAMAN_ASIMI (ZAMAN_ASIMI)
    ) u_zaman_asimi_sayaci (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .temizle_i  (sayac_temizle),
        .sayac_en_i (sayac_en),
        .son_o      (sayac_son)
    );

    // Accept-time source is chosen by gc_aktif_i; wait-time source by state.
    assign kabul_gecerli = gc_aktif_i ? gc_veri_gecerli_i : bellek_veri_hazir_i;
    assign kabul_veri    = gc_aktif_i ? gc_okunan_veri_i  : bellek_veri_i;
    assign bekle_gecerli = (durum_q == GC_BEKLE) ? gc_veri_gecerli_i : bellek_veri_hazir_i;
    assign bekle_veri    = (durum_q == GC_BEKLE) ? gc_okunan_veri_i  : bellek_veri_i;

    always_comb begin
        durum_d          = durum_q;
        bekleyen_adres_d = bekleyen_adres_q;
        bekleyen_yaz_d   = bekleyen_yaz_q;
        yaz_d            = 1'b0;
        yazmac_adres_d   = yazmac_adres_q;
        yazmac_veri_d    = yazmac_veri_q;
        hata_d           = hata_q;
        tamamlandi       = 1'b0;
        sayac_temizle    = 1'b0;
        sayac_en         = 1'b0;
        durdur_o         = 1'b0;

        case (durum_q)
            BOSTA: begin
                sayac_temizle = 1'b1;
                if (!bellekten_oku_i && yazmaca_yaz_i) begin
                    tamamlandi = 1'b1;
                    if (yazma_izni(yazmaca_yaz_i, hedef_yazmaci_i)) begin
                        yaz_d          = 1'b1;
                        yazmac_adres_d = hedef_yazmaci_i;
                        yazmac_veri_d  = hedef_yazmac_verisi_i;
                    end
                end else if (bellekten_oku_i) begin
                    if (kabul_gecerli) begin
                        tamamlandi = 1'b1;
                        if (yazma_izni(yazmaca_yaz_i, hedef_yazmaci_i)) begin
                            yaz_d          = 1'b1;
                            yazmac_adres_d = hedef_yazmaci_i;
                            yazmac_veri_d  = kabul_veri;
                        end
                    end else begin
                        bekleyen_adres_d = hedef_yazmaci_i;
                        bekleyen_yaz_d   = yazmaca_yaz_i;
                        durum_d          = gc_aktif_i ? GC_BEKLE : BELLEK_BEKLE;
                    end
                end
            end

            BELLEK_BEKLE, GC_BEKLE: begin
                if (bekle_gecerli) begin
                    // Data on the terminal-count cycle still wins over the timeout.
                    tamamlandi    = 1'b1;
                    sayac_temizle = 1'b1;
                    durum_d       = BOSTA;
                    if (yazma_izni(bekleyen_yaz_q, bekleyen_adres_q)) begin
                        yaz_d          = 1'b1;
                        yazmac_adres_d = bekleyen_adres_q;
                        yazmac_veri_d  = bekle_veri;
                    end
                end else if (sayac_son) begin
                    durdur_o      = 1'b1;
                    hata_d        = 1'b1;
                    sayac_temizle = 1'b1;
                    durum_d       = BOSTA;
                end else begin
                    durdur_o = 1'b1;
                    sayac_en = 1'b1;
                end
            end

            default: begin
                durum_d       = BOSTA;
                sayac_temizle = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q          <= BOSTA;
            bekleyen_adres_q <= '0;
            bekleyen_yaz_q   <= 1'b0;
            yaz_q            <= 1'b0;
            yazmac_adres_q   <= '0;
            yazmac_veri_q    <= '0;
            hata_q           <= 1'b0;
        end else begin
            durum_q          <= durum_d;
            bekleyen_adres_q <= bekleyen_adres_d;
            bekleyen_yaz_q   <= bekleyen_yaz_d;
            yaz_q            <= yaz_d;
            yazmac_adres_q   <= yazmac_adres_d;
            yazmac_veri_q    <= yazmac_veri_d;
            hata_q           <= hata_d;
        end
    end

`ifdef GERI_YAZ_SAYAC_EN
    logic [63:0] emekli_q, emekli_d;

    always_comb begin
        emekli_d = emekli_q;
        if (tamamlandi) begin
            emekli_d = emekli_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            emekli_q <= '0;
        end else begin
            emekli_q <= emekli_d;
        end
    end

    assign emekli_sayac_o = emekli_q;
`else
    logic tamamlandi_kullanilmaz;
    assign tamamlandi_kullanilmaz = tamamlandi;
`endif

    assign yaz_o           = yaz_q;
    assign yazmac_adres_o  = yazmac_adres_q;
    assign yazmac_veri_o   = yazmac_veri_q;
    assign ileri_gecerli_o = yaz_q;
    assign ileri_adres_o   = yazmac_adres_q;
    assign ileri_veri_o    = yazmac_veri_q;
    assign hata_o          = hata_q;

endmodule

`default_nettype wire

// File: tb/tb_geri_yaz_asamasi.sv
// ============================================================================
// tb_geri_yaz_asamasi: vector table plus hand sequences, write scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_geri_yaz_asamasi;

    localparam int VB = 32;
    localparam int ZA = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [VB-1:0] hedef_veri;
    logic          yaz_i;
    logic [4:0]    hedef_idx;
    logic          oku_i;
    logic          gc_i;
    logic          bh_i;
    logic [VB-1:0] bv_i;
    logic          gg_i;
    logic [VB-1:0] gv_i;

    logic          yaz_o;
    logic [4:0]    yazmac_adres_o;
    logic [VB-1:0] yazmac_veri_o;
    logic          ileri_gecerli_o;
    logic [4:0]    ileri_adres_o;
    logic [VB-1:0] ileri_veri_o;
    logic          durdur_o;
    logic          hata_o;
`ifdef GERI_YAZ_SAYAC_EN
    logic [63:0]   emekli_sayac;
    logic [63:0]   emekli_once;
`endif

    geri_yaz_asamasi #(
        .VERI_BIT    (VB),
        .ZAMAN_ASIMI (ZA)
    ) u_dut (
        .clk_i                 (clk),
        .rst_i                 (rst_n),
        .hedef_yazmac_verisi_i (hedef_veri),
        .yazmaca_yaz_i         (yaz_i),
        .hedef_yazmaci_i       (hedef_idx),
        .bellekten_oku_i       (oku_i),
        .gc_aktif_i            (gc_i),
        .bellek_veri_hazir_i   (bh_i),
        .bellek_veri_i         (bv_i),
        .gc_veri_gecerli_i     (gg_i),
        .gc_okunan_veri_i      (gv_i),
        .yaz_o                 (yaz_o),
        .yazmac_adres_o        (yazmac_adres_o),
        .yazmac_veri_o         (yazmac_veri_o),
        .ileri_gecerli_o       (ileri_gecerli_o),
        .ileri_adres_o         (ileri_adres_o),
        .ileri_veri_o          (ileri_veri_o),
        .durdur_o              (durdur_o),
        .hata_o                (hata_o)
`ifdef GERI_YAZ_SAYAC_EN
        ,
        .emekli_sayac_o        (emekli_sayac)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          yaz;
        logic [4:0]    idx;
        logic [VB-1:0] veri;
        logic          oku;
        logic          gc;
        logic          bh;
        logic [VB-1:0] bv;
        logic          gg;
        logic [VB-1:0] gv;
        logic          exp_yaz;
        logic [4:0]    exp_adr;
        logic [VB-1:0] exp_veri;
    } vek_t;

    typedef struct packed {
        logic [4:0]    adr;
        logic [VB-1:0] veri;
    } yazma_t;

    yazma_t beklenen_q[$];
    vek_t   tablo[8];
    int     checks = 0;
    int     failures = 0;
    int     durdur_say = 0;

    task automatic kontrol(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        checks++;
        if (gercek !== beklenen) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", ad, gercek, beklenen);
        end
    endtask

    function automatic vek_t v(input logic yaz, input logic [4:0] idx, input logic [VB-1:0] veri,
                               input logic oku, input logic gc, input logic bh, input logic [VB-1:0] bv,
                               input logic gg, input logic [VB-1:0] gv,
                               input logic ey, input logic [4:0] ea, input logic [VB-1:0] ev);
        vek_t r;
        r.yaz = yaz; r.idx = idx; r.veri = veri; r.oku = oku; r.gc = gc;
        r.bh = bh; r.bv = bv; r.gg = gg; r.gv = gv;
        r.exp_yaz = ey; r.exp_adr = ea; r.exp_veri = ev;
        return r;
    endfunction

    // Drives one cycle of inputs and books the write it should produce next cycle.
    task automatic uygula(input vek_t x);
        yaz_i = x.yaz; hedef_idx = x.idx; hedef_veri = x.veri; oku_i = x.oku; gc_i = x.gc;
        bh_i = x.bh; bv_i = x.bv; gg_i = x.gg; gv_i = x.gv;
        if (x.exp_yaz) beklenen_q.push_back({x.exp_adr, x.exp_veri});
    endtask

    task automatic bosta();
        uygula(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic surec(input logic exp_durdur, input string ad);
        #2;
        kontrol(ad, {63'd0, durdur_o}, {63'd0, exp_durdur});
        if (durdur_o === 1'b1) durdur_say++;
        @(negedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (yaz_o !== 1'b0 || ileri_gecerli_o !== 1'b0)) begin
            if (beklenen_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL beklenmeyen_yazma: got adres=%0d veri=0x%0h expected no write",
                         yazmac_adres_o, yazmac_veri_o);
            end else begin
                yazma_t e;
                e = beklenen_q.pop_front();
                kontrol("yaz_ileri_gecerli", {62'd0, yaz_o, ileri_gecerli_o}, 64'd3);
                kontrol("yazma_adres", {59'd0, yazmac_adres_o}, {59'd0, e.adr});
                kontrol("yazma_veri", {32'd0, yazmac_veri_o}, {32'd0, e.veri});
                kontrol("ileri_adres_veri", {27'd0, ileri_adres_o, ileri_veri_o}, {27'd0, e.adr, e.veri});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL zaman_siniri: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        tablo[0] = v(1, 5,  32'h12345678, 0, 0, 0, 0,            0, 0,            1, 5,  32'h12345678);
        tablo[1] = v(1, 6,  32'hA5A5A5A5, 0, 0, 1, 32'h1,        1, 32'h2,        1, 6,  32'hA5A5A5A5);
        tablo[2] = v(1, 0,  32'hFFFF0000, 0, 0, 0, 0,            0, 0,            0, 0,  0);
        tablo[3] = v(0, 7,  32'h77777777, 0, 0, 0, 0,            0, 0,            0, 0,  0);
        tablo[4] = v(1, 9,  32'h11111111, 1, 0, 1, 32'hCAFEF00D, 1, 32'h0BAD0BAD, 1, 9,  32'hCAFEF00D);
        tablo[5] = v(1, 31, 32'h11111111, 1, 1, 1, 32'h0DDF00D0, 1, 32'h0BADC0DE, 1, 31, 32'h0BADC0DE);
        tablo[6] = v(0, 3,  32'h0,        1, 0, 1, 32'h33333333, 0, 0,            0, 0,  0);
        tablo[7] = v(1, 1,  32'h76543210, 0, 0, 0, 0,            0, 0,            1, 1,  32'h76543210);

        bosta();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        kontrol("reset_yaz", {62'd0, yaz_o, ileri_gecerli_o}, 64'd0);
        kontrol("reset_adres", {54'd0, yazmac_adres_o, ileri_adres_o}, 64'd0);
        kontrol("reset_veri", {yazmac_veri_o, ileri_veri_o}, 64'd0);
        kontrol("reset_durdur_hata", {62'd0, durdur_o, hata_o}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            uygula(tablo[i]);
            surec(1'b0, $sformatf("tablo_%0d_durdur", i));
        end
        bosta();
        surec(1'b0, "tablo_son");
        kontrol("darbe_tek_cevrim", {63'd0, yaz_o}, 64'd0);
        kontrol("adres_veri_tut", {27'd0, yazmac_adres_o, yazmac_veri_o}, {27'd0, 5'd1, 32'h76543210});

        // Cache load: three empty wait cycles, unrelated inputs toggling meanwhile.
        durdur_say = 0;
        uygula(v(1, 10, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        surec(1'b0, "s1_kabul");
        for (int k = 0; k < 3; k++) begin
            uygula(v(1, 20, 32'h999, 1, 1, 0, 32'h1, 1, 32'h55, 0, 0, 0));
            surec(1'b1, "s1_bekle");
        end
        uygula(v(0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0, 1, 10, 32'hDEADBEEF));
        surec(1'b0, "s1_veri");
        bosta();
        surec(1'b0, "s1_sonra");
        kontrol("s1_durdur_say", durdur_say, 3);

        // I/O load to x0: stalls, consumes data, never writes.
        durdur_say = 0;
`ifdef GERI_YAZ_SAYAC_EN
        emekli_once = emekli_sayac;
`endif
        uygula(v(1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        surec(1'b0, "s2_kabul");
        for (int k = 0; k < 2; k++) begin
            uygula(v(0, 0, 0, 0, 0, 1, 32'h1111, 0, 0, 0, 0, 0));
            surec(1'b1, "s2_bekle");
        end
        uygula(v(0, 0, 0, 0, 0, 0, 0, 1, 32'hABCD0123, 0, 0, 0));
        surec(1'b0, "s2_veri");
`ifdef GERI_YAZ_SAYAC_EN
        kontrol("s2_emekli", emekli_sayac, emekli_once + 64'd1);
`endif
        uygula(v(1, 2, 32'h22222222, 0, 0, 0, 0, 0, 0, 1, 2, 32'h22222222));
        surec(1'b0, "s2_bosta_kabul");
        bosta();
        surec(1'b0, "s2_sonra");
        kontrol("s2_durdur_say", durdur_say, 2);

        // Data arriving on the terminal-count wait cycle beats the timeout.
        durdur_say = 0;
        uygula(v(1, 14, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        surec(1'b0, "s4_kabul");
        for (int k = 0; k < ZA - 1; k++) begin
            bosta();
            surec(1'b1, "s4_bekle");
        end
        uygula(v(0, 0, 0, 0, 0, 1, 32'h5EED5EED, 0, 0, 1, 14, 32'h5EED5EED));
        surec(1'b0, "s4_son_cevrim");
        bosta();
        surec(1'b0, "s4_sonra");
        kontrol("s4_durdur_say", durdur_say, ZA - 1);
        kontrol("s4_hata_yok", {63'd0, hata_o}, 64'd0);

        // Timeout: data never comes.
        durdur_say = 0;
        uygula(v(1, 12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        surec(1'b0, "s3_kabul");
        for (int k = 0; k < ZA; k++) begin
            bosta();
            surec(1'b1, "s3_bekle");
        end
        kontrol("s3_hata_gec_degil", {63'd0, hata_o}, 64'd1);
        kontrol("s3_durdur_say", durdur_say, ZA);
        uygula(v(0, 0, 0, 0, 0, 1, 32'hBAADBAAD, 0, 0, 0, 0, 0));
        surec(1'b0, "s3_gec_veri");
        uygula(v(1, 13, 32'h13131313, 0, 0, 0, 0, 0, 0, 1, 13, 32'h13131313));
        surec(1'b0, "s3_sonraki_komut");
        bosta();
        surec(1'b0, "s3_sonra");
        kontrol("s3_hata_yapiskan", {63'd0, hata_o}, 64'd1);

        // Asynchronous reset in the second wait cycle aborts the pending write.
        uygula(v(1, 15, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        surec(1'b0, "s5_kabul");
        bosta();
        surec(1'b1, "s5_bekle1");
        bosta();
        #2 rst_n = 1'b0;
        #1;
        kontrol("s5_reset_yaz", {62'd0, yaz_o, ileri_gecerli_o}, 64'd0);
        kontrol("s5_reset_adres", {54'd0, yazmac_adres_o, ileri_adres_o}, 64'd0);
        kontrol("s5_reset_veri", {yazmac_veri_o, ileri_veri_o}, 64'd0);
        kontrol("s5_reset_durdur_hata", {62'd0, durdur_o, hata_o}, 64'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        bosta();
        surec(1'b0, "s5_birakma");
        uygula(v(0, 0, 0, 0, 0, 1, 32'hFEEDFACE, 0, 0, 0, 0, 0));
        surec(1'b0, "s5_gec_veri");
        bosta();
        surec(1'b0, "s5_sonra");
        kontrol("s5_yazma_yok", {63'd0, yaz_o}, 64'd0);

        kontrol("kuyruk_bos", beklenen_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
